// File: rtl/spike_merge_router_if.sv
// ---------------------------------------------------------------------------
// spike_merge_router_if
//   Valid/ready packet stream used on both sides of the spike router.
//   Ports (signals carried):
//     data   PKT_W  packet payload {ts, id, valid, eop}, MSB first
//     valid  1      producer has a packet on data
//     ready  1      consumer accepts the packet this cycle
//   Modports:
//     master  drives data/valid, samples ready
//     slave   samples data/valid, drives ready
// ---------------------------------------------------------------------------
interface spike_merge_router_if #(
    parameter int PKT_W = 32
) ();
    logic [PKT_W-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/spike_merge_router.sv
// ---------------------------------------------------------------------------
// spike_merge_router
//   Merges local neuron spikes and an external packet stream into a single
//   ordered output stream. Local spikes are latched into a pending mask, a
//   round-robin encoder turns the mask into packets, and a fair arbiter
//   shares the FIFO write port between the encoder and the external input.
//   A one-entry output register in front of the FIFO holds data stable
//   until the downstream accepts it.
//
//   Ports:
//     clk            sole clock, rising edge
//     rst_n          asynchronous, active-low reset
//     neuron_spikes  one-cycle spike pulses, one bit per local neuron
//     spike_in       slave stream: external packets in
//     spike_out      master stream: merged packets out {ts, id, 1, 1}
//     drop_count     saturating count of lost local spikes
//     fifo_level     packets held in FIFO plus output register
//
//   Optional feature macro:
//     SPIKE_MERGE_ROUTER_RESTAMP_EN  when defined, the ts field of external
//                                    packets is replaced by the local ts
//                                    counter at FIFO write.
// ---------------------------------------------------------------------------
module spike_merge_router #(
    parameter  int NUM_NEURONS = 35,
    parameter  int TS_WIDTH    = 16,
    parameter  int ID_WIDTH    = 14,
    parameter  int FIFO_DEPTH  = 256,
    parameter  int HEADROOM    = 16,
    localparam int PKT_W       = TS_WIDTH + ID_WIDTH + 2,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_NEURONS-1:0] neuron_spikes,
    spike_merge_router_if.slave    spike_in,
    spike_merge_router_if.master   spike_out,
    output logic [15:0]            drop_count,
    output logic [LVL_W-1:0]       fifo_level
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int NIDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    typedef enum logic {GRANT_EXT = 1'b0, GRANT_ENC = 1'b1} grant_e;

    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] grant_onehot, drops;
    logic [NIDX_W-1:0]      rr_ptr_q, rr_ptr_d, enc_id;
    grant_e                 last_grant_q, last_grant_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PKT_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PKT_W-1:0]       out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   enc_found, enc_req, ext_space, ext_req;
    logic                   enc_grant, ext_grant, wr_en;
    logic                   mem_empty, out_load, out_fire;
    logic [PKT_W-1:0]       wr_data;
    logic [16:0]            drop_sum;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [16:0] b);
        logic [17:0] s;
        s = 18'(a) + 18'(b);
        return (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    // Round-robin encoder: first pending index at or after rr_ptr, else the
    // lowest pending index (the wrap-around case).
    always_comb begin
        enc_found = 1'b0;
        enc_id    = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (!enc_found && pending_q[i] && (NIDX_W'(i) >= rr_ptr_q)) begin
                enc_found = 1'b1;
                enc_id    = NIDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (!enc_found && pending_q[i]) begin
                enc_found = 1'b1;
                enc_id    = NIDX_W'(i);
            end
        end
    end

    // Write-port arbiter. last_grant only moves on a real conflict, so a
    // lone requester never disturbs the alternation order.
    always_comb begin
        enc_req      = (|pending_q) && (level_q < LVL_W'(FIFO_DEPTH));
        ext_space    = level_q <= LVL_W'(FIFO_DEPTH - HEADROOM - 1);
        ext_req      = spike_in.valid && ext_space;
        enc_grant    = enc_req && (!ext_req || last_grant_q == GRANT_EXT);
        ext_grant    = ext_req && (!enc_req || last_grant_q == GRANT_ENC);
        wr_en        = enc_grant || ext_grant;
        last_grant_d = last_grant_q;
        if (enc_req && ext_req) begin
            last_grant_d = enc_grant ? GRANT_ENC : GRANT_EXT;
        end
    end

    // Ready is a function of state only; it predicts who wins a conflict.
    assign spike_in.ready = ext_space && (!enc_req || last_grant_q == GRANT_ENC);

`ifdef SPIKE_MERGE_ROUTER_RESTAMP_EN
    logic unused_in_ts;
    assign unused_in_ts = ^spike_in.data[PKT_W-1:PKT_W-TS_WIDTH];
`endif

    always_comb begin
        if (enc_grant) begin
            wr_data = {ts_q, ID_WIDTH'(enc_id), 2'b11};
        end else begin
`ifdef SPIKE_MERGE_ROUTER_RESTAMP_EN
            wr_data = {ts_q, spike_in.data[PKT_W-TS_WIDTH-1:0]};
`else
            wr_data = spike_in.data;
`endif
        end
    end

    // Capture, drop accounting and encoder pointer.
    always_comb begin
        grant_onehot = '0;
        if (enc_grant) begin
            grant_onehot[enc_id] = 1'b1;
        end
        drops     = neuron_spikes & pending_q & ~grant_onehot;
        pending_d = (pending_q & ~grant_onehot) | neuron_spikes;
        drop_sum  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            drop_sum = drop_sum + 17'(drops[i]);
        end
        drop_count_d = sat_add16(drop_count_q, drop_sum);
        rr_ptr_d     = rr_ptr_q;
        if (enc_grant) begin
            rr_ptr_d = (enc_id == NIDX_W'(NUM_NEURONS - 1)) ? '0 : enc_id + NIDX_W'(1);
        end
        ts_d = ts_q + TS_WIDTH'(1);
    end

    // FIFO pointers and output register. The output register refills from
    // the FIFO head whenever it is empty or being accepted this cycle.
    always_comb begin
        mem_empty   = (wr_ptr_q == rd_ptr_q);
        out_load    = !out_valid_q || spike_out.ready;
        out_fire    = out_valid_q && spike_out.ready;
        wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_load) begin
            out_valid_d = !mem_empty;
            if (!mem_empty) begin
                out_data_d = mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            end
        end
        level_d = level_q + LVL_W'(wr_en) - LVL_W'(out_fire);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            last_grant_q <= GRANT_EXT;
            drop_count_q <= '0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            ts_q         <= ts_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            last_grant_q <= last_grant_d;
            drop_count_q <= drop_count_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign spike_out.data  = out_data_q;
    assign spike_out.valid = out_valid_q;
    assign drop_count      = drop_count_q;
    assign fifo_level      = level_q;
endmodule

// File: tb/tb_spike_merge_router.sv
// ---------------------------------------------------------------------------
// tb_spike_merge_router
//   Randomised and directed stimulus for spike_merge_router. A reference
//   model advanced once per clock edge predicts written packets (pushed to a
//   scoreboard queue), occupancy, drop count, input ready and output valid.
//   A separate monitor compares the DUT against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_spike_merge_router;
    localparam int N     = 35;
    localparam int FD    = 256;
    localparam int HR    = 16;
    localparam int PKT_W = 32;
    localparam int LVL_W = 9;

`ifdef SPIKE_MERGE_ROUTER_RESTAMP_EN
    localparam logic [31:0] EXP_RESTAMP = 32'h0010_0007;
`else
    localparam logic [31:0] EXP_RESTAMP = 32'hABCD_0007;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     spikes = '0;
    logic [15:0]      drop_count;
    logic [LVL_W-1:0] fifo_level;

    spike_merge_router_if #(.PKT_W(PKT_W)) bus_in ();
    spike_merge_router_if #(.PKT_W(PKT_W)) bus_out ();

    spike_merge_router #(
        .NUM_NEURONS(N), .TS_WIDTH(16), .ID_WIDTH(14), .FIFO_DEPTH(FD), .HEADROOM(HR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .neuron_spikes(spikes),
        .spike_in(bus_in),
        .spike_out(bus_out),
        .drop_count(drop_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference model state
    bit [N-1:0]  m_pend;
    int          m_rr, m_level, m_ts, m_drop, m_edge;
    bit          m_last_enc, m_valid, m_in_ready;
    int          mq[$];            // write edge of every packet still held
    logic [31:0] sb[$];            // expected packets, oldest first

    function automatic void model_reset();
        m_pend = '0; m_rr = 0; m_level = 0; m_ts = 0; m_drop = 0; m_edge = 0;
        m_last_enc = 1'b0; m_valid = 1'b0; m_in_ready = 1'b1;
        mq.delete(); sb.delete();
    endfunction

    function automatic void model_step();
        bit enc_req, ext_req, g_enc, g_ext, fire;
        int id, d;
        logic [31:0] pkt;
        enc_req = (m_pend != '0) && (m_level < FD);
        ext_req = bus_in.valid && (m_level <= FD - HR - 1);
        if (enc_req && ext_req) begin
            g_enc = !m_last_enc; g_ext = m_last_enc; m_last_enc = g_enc;
        end else begin
            g_enc = enc_req; g_ext = ext_req;
        end
        id = -1;
        if (g_enc)
            for (int k = 0; k < N; k++)
                if (id < 0 && m_pend[(m_rr + k) % N]) id = (m_rr + k) % N;
        d = 0;
        for (int i = 0; i < N; i++)
            if (spikes[i] && m_pend[i] && !(g_enc && i == id)) d++;
        m_drop = (m_drop + d > 65535) ? 65535 : m_drop + d;
        if (g_enc) begin
            m_pend[id] = 1'b0;
            m_rr = (id + 1) % N;
        end
        m_pend = m_pend | spikes;
        fire = m_valid && bus_out.ready;
        m_edge++;
        if (fire) void'(mq.pop_front());
        if (g_enc) begin
            pkt = {m_ts[15:0], id[13:0], 2'b11};
            sb.push_back(pkt); mq.push_back(m_edge);
        end
        if (g_ext) begin
`ifdef SPIKE_MERGE_ROUTER_RESTAMP_EN
            pkt = {m_ts[15:0], bus_in.data[15:0]};
`else
            pkt = bus_in.data;
`endif
            sb.push_back(pkt); mq.push_back(m_edge);
        end
        m_level = m_level + ((g_enc || g_ext) ? 1 : 0) - (fire ? 1 : 0);
        m_ts = (m_ts + 1) % 65536;
        m_valid = (mq.size() > 0) && (mq[0] < m_edge);
        enc_req = (m_pend != '0) && (m_level < FD);
        m_in_ready = (m_level <= FD - HR - 1) && (!enc_req || m_last_enc);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // Monitor: state checks every cycle; packet checks while output is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", 64'(bus_out.valid), 64'(m_valid));
                chk("fifo_level", 64'(fifo_level), 64'(m_level));
                chk("drop_count", 64'(drop_count), 64'(m_drop));
                chk("in_ready", 64'(bus_in.ready), 64'(m_in_ready));
                if (bus_out.valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL out_data: got 0x%0h, expected no packet", bus_out.data);
                    end else begin
                        chk("out_data", 64'(bus_out.data), 64'(sb[0]));
                        if (bus_out.ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus_in.valid  = 1'b0;
        bus_in.data   = '0;
        bus_out.ready = 1'b1;
        model_reset();
        repeat (3) tick();
        chk("rst_out_valid", 64'(bus_out.valid), 64'd0);
        chk("rst_out_data", 64'(bus_out.data), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_in_ready", 64'(bus_in.ready), 64'd1);
        rst_n = 1'b1;

        // Restamp: packet accepted on the edge where ts == 0x0010
        repeat (16) tick();
        bus_in.data = 32'hABCD_0007; bus_in.valid = 1'b1;
        tick();
        bus_in.valid = 1'b0;
        tick();
        chk("restamp_valid", 64'(bus_out.valid), 64'd1);
        chk("restamp_data", 64'(bus_out.data), 64'(EXP_RESTAMP));
        repeat (3) tick();

        // Simultaneous capture of neurons 0,1,2
        spikes = 35'b111;
        tick();
        spikes = '0;
        tick();
        chk("lat_n1_valid", 64'(bus_out.valid), 64'd0);
        tick();
        chk("lat_n2_valid", 64'(bus_out.valid), 64'd1);
        chk("lat_n2_id", 64'(bus_out.data[15:2]), 64'd0);
        repeat (6) tick();
        chk("sim_drop", 64'(drop_count), 64'd0);

        // Round-robin between neurons 0 and 5
        repeat (20) begin
            spikes = '0; spikes[0] = 1'b1; spikes[5] = 1'b1;
            tick();
        end
        spikes = '0;
        repeat (10) tick();

        // External / encoder conflict
        repeat (24) begin
            spikes = '0; spikes[3] = 1'b1;
            bus_in.valid = 1'b1; bus_in.data = $urandom;
            tick();
        end
        spikes = '0; bus_in.valid = 1'b0;
        repeat (10) tick();

        // Backpressure with continuous external input
        bus_out.ready = 1'b0;
        repeat (300) begin
            bus_in.valid = 1'b1; bus_in.data = $urandom;
            tick();
        end
        chk("bp_level", 64'(fifo_level), 64'(FD - HR));
        chk("bp_in_ready", 64'(bus_in.ready), 64'd0);
        bus_in.valid = 1'b0; bus_out.ready = 1'b1;
        repeat (300) tick();

        // Random mixed traffic
        repeat (2000) begin
            for (int i = 0; i < N; i++) spikes[i] = ($urandom_range(0, 15) == 0);
            bus_in.valid  = $urandom_range(0, 1) == 1;
            bus_in.data   = $urandom;
            bus_out.ready = $urandom_range(0, 3) != 0;
            tick();
        end

        // Asynchronous reset between edges, mid-burst
        #2;
        rst_n = 1'b0;
        spikes = '0; bus_in.valid = 1'b0; bus_out.ready = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 64'(bus_out.valid), 64'd0);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_drop", 64'(drop_count), 64'd0);
        tick();
        rst_n = 1'b1;
        spikes[7] = 1'b1;
        tick();
        spikes = '0;
        repeat (6) tick();

        // Final drain
        for (int k = 0; k < 600 && m_level != 0; k++) tick();
        tick();
        chk("final_level", 64'(fifo_level), 64'd0);
        chk("final_sb_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spike_merge_router.md
# spike_merge_router

Parametrised spike router that merges local neuron spikes and an external spike stream into one ordered output packet stream. It captures every spike into a pending mask, so simultaneous spikes are never lost. A round-robin encoder serialises the mask at one packet per cycle, and a second arbiter shares the single FIFO write port fairly between the encoder and the external input. It sits between the neuron array and the inter-core spike fabric, with a proper hold-until-ready output handshake.

## Interface
- NUM_NEURONS, 35: number of local neurons; must be ≤ 2^ID_WIDTH.
- TS_WIDTH, 16: timestamp field width.
- ID_WIDTH, 14: neuron-ID field width. PKT_W = TS_WIDTH+ID_WIDTH+2.
- FIFO_DEPTH, 256: packet FIFO depth; power of two, ≥ 4.
- HEADROOM, 16: free entries reserved for the encoder; external input is refused when count > FIFO_DEPTH-HEADROOM-1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- neuron_spikes  in  NUM_NEURONS  one-cycle spike pulses, sampled every edge.
- spike_in_data  in  PKT_W  external packet.
- spike_in_valid  in  1  external packet valid.
- spike_in_ready  out  1  combinational accept; depends on state only, never on spike_in_valid.
- spike_out_data  out  PKT_W  packet {ts, id, valid=1, eop=1}, MSB first.
- spike_out_valid  out  1  output valid; held with stable data until accepted.
- spike_out_ready  in  1  downstream accept.
- drop_count  out  16  saturating count of lost local spikes.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Free-running ts counter increments every cycle and wraps modulo 2^TS_WIDTH.
- Capture: pending <= (pending & ~grant_onehot) | neuron_spikes.
- Drop: a spike on neuron i is a drop when pending[i] is already set and i is not granted this cycle. Each cycle adds popcount(drops) to drop_count, saturating at 0xFFFF.
- Encoder: selects the first pending index at or after rr_ptr, wrapping at NUM_NEURONS. On write, rr_ptr <= index+1, wrapping to 0.
- Encoder requests only when pending is non-zero and count < FIFO_DEPTH.
- External request: spike_in_valid with count ≤ FIFO_DEPTH-HEADROOM-1.
- Write arbiter: on conflict, the grant goes to the opposite of last_grant; last_grant updates only on a conflict. With a single requester, that requester wins.
- spike_in_ready = ext_space && (!enc_req || last_grant==ENC).
- Encoder packet: {ts, id, 1, 1}, where ts is the counter value in the write cycle.
- Output stage: one-entry register in front of the FIFO. It loads when empty or when spike_out_valid && spike_out_ready.
- Output stage never drops or duplicates a packet.
- fifo_level counts the FIFO plus the output register. A simultaneous write and pop leaves the count unchanged.

## Timing
- Reset (asynchronous, immediate) clears all state:
  - spike_out_valid=0, spike_out_data=0, drop_count=0, fifo_level=0.
  - pending=0, rr_ptr=0, ts=0, last_grant=EXT.
  - spike_in_ready is therefore 1 after reset.
- Reset mid-operation discards all queued and pending spikes. spike_out_valid falls without waiting for a clock.
- Latency, empty and idle system: spike at edge N is captured at N; FIFO write at N+1; spike_out_valid high after N+2.
- External packet accepted at edge N: spike_out_valid high after N+1.
- Full FIFO: the encoder stalls and pending is retained. Only repeat spikes on already-pending neurons count as drops.
- pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH.
- Throughput: one write and one read per cycle sustained.

## Configuration
- SPIKE_MERGE_ROUTER_RESTAMP_EN defined: an external packet's ts field is overwritten with the local counter at write; ID and flag bits pass unchanged.
- Undefined: external packets pass through verbatim.

## Test plan
- Simultaneous capture: neuron_spikes=0b111 for one cycle with ready=1 → IDs 0,1,2 emitted on consecutive cycles. Timestamps are consecutive; first valid after edge N+2; drop_count=0.
- Round-robin fairness: neurons 0 and 5 spike every cycle, 1 cycle apart → output alternates IDs 0,5. Repeats on still-pending neurons increment drop_count.
- Ext/encoder conflict: spike_in_valid held high and neuron 3 spiking → output interleaves ext, enc, ext, enc. spike_in_ready is low exactly on encoder-grant cycles.
- Backpressure: spike_out_ready=0 for 300 cycles with continuous external input → spike_in_ready drops when fifo_level=FIFO_DEPTH-HEADROOM. Output data stays stable; after release, every accepted packet appears in order.
- Restamp: with the macro, ext packet 0xABCD_0007 accepted at ts=0x0010 → 0x0010_0007 output. Without the macro → 0xABCD_0007 output.
- Async reset: assert rst_n=0 mid-burst between edges → spike_out_valid=0 immediately. After release: fifo_level=0, drop_count=0, first new spike ts starts near 0.
